// File: rtl/bb_lcd_rx.sv
// Two-digit 7-segment LCD receiver. Samples the AC-driven segment lines a
// fixed settle time after each common-electrode edge, checks DC balance
// between the two phases, decodes to BCD, and publishes a digit pair once it
// has been seen unchanged in AGREE_N consecutive clean frames.
module bb_lcd_rx #(
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned AGREE_N     = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcdcom_i,
  input  logic [6:0] lcdseg1_i,
  input  logic [6:0] lcdseg2_i,
  output logic [3:0] digit1_o,
  output logic [3:0] digit2_o,
  output logic       valid_o,
  output logic       upd_o,
  output logic       err_pat_o,
  output logic       err_dc_o,
  output logic       com_lost_o
);

  typedef enum logic [1:0] {StWaitEdge, StSettle, StEval} state_e;

  localparam logic [7:0]  SettleLast = 8'(SETTLE_CYC - 1);
  localparam logic [2:0]  AgreeMax   = 3'(AGREE_N);
  localparam logic [15:0] TmoMax     = 16'(TIMEOUT_CYC);
  localparam logic [15:0] TmoLast    = 16'(TIMEOUT_CYC - 1);

  // Returns {pattern_error, bcd}; unknown patterns decode to 4'hF.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h3F:   return {1'b0, 4'd0};
      7'h06:   return {1'b0, 4'd1};
      7'h5B:   return {1'b0, 4'd2};
      7'h4F:   return {1'b0, 4'd3};
      7'h66:   return {1'b0, 4'd4};
      7'h6D:   return {1'b0, 4'd5};
      7'h7D:   return {1'b0, 4'd6};
      7'h07:   return {1'b0, 4'd7};
      7'h7F:   return {1'b0, 4'd8};
      7'h6F:   return {1'b0, 4'd9};
      default: return {1'b1, 4'hF};
    endcase
  endfunction

  // Synchronizer and edge-detect flops
  logic       com_m_q, com_s_q, com_r_q;
  logic [6:0] seg1_m_q, seg1_s_q, seg2_m_q, seg2_s_q;

  state_e     state_q, state_d;
  logic [7:0] settle_q, settle_d;
  logic [15:0] tmo_q, tmo_d;
  logic [6:0] cap1_q, cap1_d, cap2_q, cap2_d;
  logic       cap_ph_q, cap_ph_d;
  logic [6:0] a1_q, a1_d, a2_q, a2_d;
  logic       pha_q, pha_d;
  logic [2:0] agree_q, agree_d;
  logic [3:0] prev1_q, prev1_d, prev2_q, prev2_d;
  logic [3:0] digit1_q, digit1_d, digit2_q, digit2_d;
  logic       valid_q, valid_d, upd_q, upd_d;
  logic       err_pat_q, err_pat_d, err_dc_q, err_dc_d;
  logic       com_lost_q, com_lost_d;

  logic       com_edge, tmo_hit;
  logic [4:0] dec1, dec2;
  logic       frame_dc, frame_pat;
  logic [2:0] agree_nx;

  assign com_edge = com_s_q ^ com_r_q;

  // Two-flop synchronizers plus the registered copy of com_s for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      com_m_q  <= 1'b0;
      com_s_q  <= 1'b0;
      com_r_q  <= 1'b0;
      seg1_m_q <= '0;
      seg1_s_q <= '0;
      seg2_m_q <= '0;
      seg2_s_q <= '0;
    end else begin
      com_m_q  <= lcdcom_i;
      com_s_q  <= com_m_q;
      com_r_q  <= com_s_q;
      seg1_m_q <= lcdseg1_i;
      seg1_s_q <= seg1_m_q;
      seg2_m_q <= lcdseg2_i;
      seg2_s_q <= seg2_m_q;
    end
  end

  // Next-state: capture FSM, frame evaluation, agreement and timeout
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    tmo_d      = tmo_q;
    cap1_d     = cap1_q;
    cap2_d     = cap2_q;
    cap_ph_d   = cap_ph_q;
    a1_d       = a1_q;
    a2_d       = a2_q;
    pha_d      = pha_q;
    agree_d    = agree_q;
    prev1_d    = prev1_q;
    prev2_d    = prev2_q;
    digit1_d   = digit1_q;
    digit2_d   = digit2_q;
    valid_d    = valid_q;
    upd_d      = 1'b0;
    err_pat_d  = err_pat_q;
    err_dc_d   = err_dc_q;
    com_lost_d = com_lost_q;
    dec1       = seg_decode(cap1_q);
    dec2       = seg_decode(cap2_q);
    frame_dc   = (a1_q != cap1_q) || (a2_q != cap2_q);
    frame_pat  = dec1[4] | dec2[4];
    agree_nx   = agree_q;
    tmo_hit    = 1'b0;

    if (com_edge) begin
      tmo_d      = '0;
      com_lost_d = 1'b0;
    end else begin
      if (tmo_q < TmoMax) tmo_d = tmo_q + 16'd1;
      tmo_hit = (tmo_q == TmoLast);
    end

    case (state_q)
      StWaitEdge: begin
        if (com_edge) begin
          state_d  = StSettle;
          settle_d = '0;
        end
      end
      StSettle: begin
        if (com_edge) begin
          settle_d = '0;
        end else if (settle_q == SettleLast) begin
          cap1_d   = seg1_s_q ^ {7{com_s_q}};
          cap2_d   = seg2_s_q ^ {7{com_s_q}};
          cap_ph_d = com_s_q;
          if (!com_s_q) begin
            a1_d  = seg1_s_q;
            a2_d  = seg2_s_q;
            pha_d = 1'b1;
          end
          state_d = StEval;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      StEval: begin
        // Phase-B capture closes a frame only if a phase-A capture preceded it
        if (cap_ph_q && pha_q) begin
          pha_d     = 1'b0;
          err_pat_d = frame_pat;
          err_dc_d  = frame_dc;
          prev1_d   = dec1[3:0];
          prev2_d   = dec2[3:0];
          if (frame_pat || frame_dc) begin
            agree_d = '0;
            valid_d = 1'b0;
          end else begin
            if ({dec1[3:0], dec2[3:0]} != {prev1_q, prev2_q}) begin
              agree_nx = 3'd1;
            end else if (agree_q >= AgreeMax) begin
              agree_nx = AgreeMax;
            end else begin
              agree_nx = agree_q + 3'd1;
            end
            agree_d = agree_nx;
            if (agree_nx == AgreeMax) begin
              upd_d    = ({dec1[3:0], dec2[3:0]} != {digit1_q, digit2_q}) || !valid_q;
              digit1_d = dec1[3:0];
              digit2_d = dec2[3:0];
              valid_d  = 1'b1;
            end
          end
        end
        // Do not lose an edge that lands on the evaluation cycle
        if (com_edge) begin
          state_d  = StSettle;
          settle_d = '0;
        end else begin
          state_d = StWaitEdge;
        end
      end
      default: state_d = StWaitEdge;
    endcase

    if (tmo_hit) begin
      com_lost_d = 1'b1;
      valid_d    = 1'b0;
      agree_d    = '0;
      pha_d      = 1'b0;
      state_d    = StWaitEdge;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StWaitEdge;
      settle_q   <= '0;
      tmo_q      <= '0;
      cap1_q     <= '0;
      cap2_q     <= '0;
      cap_ph_q   <= 1'b0;
      a1_q       <= '0;
      a2_q       <= '0;
      pha_q      <= 1'b0;
      agree_q    <= '0;
      prev1_q    <= '0;
      prev2_q    <= '0;
      digit1_q   <= '0;
      digit2_q   <= '0;
      valid_q    <= 1'b0;
      upd_q      <= 1'b0;
      err_pat_q  <= 1'b0;
      err_dc_q   <= 1'b0;
      com_lost_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      tmo_q      <= tmo_d;
      cap1_q     <= cap1_d;
      cap2_q     <= cap2_d;
      cap_ph_q   <= cap_ph_d;
      a1_q       <= a1_d;
      a2_q       <= a2_d;
      pha_q      <= pha_d;
      agree_q    <= agree_d;
      prev1_q    <= prev1_d;
      prev2_q    <= prev2_d;
      digit1_q   <= digit1_d;
      digit2_q   <= digit2_d;
      valid_q    <= valid_d;
      upd_q      <= upd_d;
      err_pat_q  <= err_pat_d;
      err_dc_q   <= err_dc_d;
      com_lost_q <= com_lost_d;
    end
  end

  assign digit1_o   = digit1_q;
  assign digit2_o   = digit2_q;
  assign valid_o    = valid_q;
  assign upd_o      = upd_q;
  assign err_pat_o  = err_pat_q;
  assign err_dc_o   = err_dc_q;
  assign com_lost_o = com_lost_q;

endmodule

// File: tb/tb_bb_lcd_rx.sv
// Bench for bb_lcd_rx: directed scenarios plus randomized frames, checked
// against a frame-level model of the receiver's published outputs.
module tb_bb_lcd_rx;

  localparam int AGREE = 2;
  localparam int HALF  = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcdcom;
  logic [6:0] lcdseg1, lcdseg2;
  logic [3:0] digit1, digit2;
  logic       valid, upd, err_pat, err_dc, com_lost;

  bb_lcd_rx #(
    .SETTLE_CYC (8),
    .AGREE_N    (AGREE),
    .TIMEOUT_CYC(4096)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lcdcom_i  (lcdcom),
    .lcdseg1_i (lcdseg1),
    .lcdseg2_i (lcdseg2),
    .digit1_o  (digit1),
    .digit2_o  (digit2),
    .valid_o   (valid),
    .upd_o     (upd),
    .err_pat_o (err_pat),
    .err_dc_o  (err_dc),
    .com_lost_o(com_lost)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int upd_seen = 0;

  // Count every cycle on which the update pulse is high
  always @(negedge clk) if (upd === 1'b1) upd_seen++;

  logic [6:0] tbl [10];

  // Frame-level model state
  int m_d1, m_d2, m_p1, m_p2, m_agree, m_upd;
  bit m_valid, m_errp, m_errdc, m_lost;

  function automatic int dec(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (p == tbl[i]) return i;
    return 15;
  endfunction

  task automatic model_reset();
    m_d1 = 0; m_d2 = 0; m_p1 = 0; m_p2 = 0; m_agree = 0;
    m_valid = 0; m_errp = 0; m_errdc = 0; m_lost = 0;
  endtask

  task automatic model_frame(input logic [6:0] a1, a2, b1, b2);
    int d1, d2;
    d1 = dec(b1);
    d2 = dec(b2);
    m_lost  = 0;
    m_errp  = (d1 == 15) || (d2 == 15);
    m_errdc = (a1 != b1) || (a2 != b2);
    if (m_errp || m_errdc) begin
      m_agree = 0;
      m_valid = 0;
    end else begin
      if (d1 == m_p1 && d2 == m_p2) m_agree = (m_agree + 1 > AGREE) ? AGREE : m_agree + 1;
      else m_agree = 1;
      if (m_agree == AGREE) begin
        if (!m_valid || d1 != m_d1 || d2 != m_d2) m_upd++;
        m_d1 = d1; m_d2 = d2; m_valid = 1;
      end
    end
    m_p1 = d1; m_p2 = d2;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".digit1"}, 32'(digit1), 32'(m_d1));
    check({tag, ".digit2"}, 32'(digit2), 32'(m_d2));
    check({tag, ".valid"}, 32'(valid), 32'(m_valid));
    check({tag, ".err_pat"}, 32'(err_pat), 32'(m_errp));
    check({tag, ".err_dc"}, 32'(err_dc), 32'(m_errdc));
    check({tag, ".com_lost"}, 32'(com_lost), 32'(m_lost));
    check({tag, ".upd_count"}, 32'(upd_seen), 32'(m_upd));
  endtask

  // One full frame: phase A (com low) then phase B (com high); args are active-segment maps
  task automatic frame(input logic [6:0] a1, a2, b1, b2, input bit glitch);
    lcdcom = 1'b0; lcdseg1 = a1; lcdseg2 = a2;
    if (glitch) begin
      wait_cyc(4);
      lcdcom = 1'b1;
      wait_cyc(2);
      lcdcom = 1'b0;
    end
    wait_cyc(HALF);
    lcdcom = 1'b1; lcdseg1 = ~b1; lcdseg2 = ~b2;
    wait_cyc(HALF);
    model_frame(a1, a2, b1, b2);
  endtask

  task automatic good_frame(input int v1, input int v2);
    frame(tbl[v1], tbl[v2], tbl[v1], tbl[v2], 1'b0);
  endtask

  initial begin
    int cur1, cur2, kind;
    logic [6:0] r, bx;
    tbl[0] = 7'h3F; tbl[1] = 7'h06; tbl[2] = 7'h5B; tbl[3] = 7'h4F; tbl[4] = 7'h66;
    tbl[5] = 7'h6D; tbl[6] = 7'h7D; tbl[7] = 7'h07; tbl[8] = 7'h7F; tbl[9] = 7'h6F;
    m_upd = 0;
    model_reset();

    rst = 1'b1; lcdcom = 1'b1; lcdseg1 = 7'h7F; lcdseg2 = 7'h7F;
    wait_cyc(5);
    check_all("reset");
    rst = 1'b0;
    wait_cyc(30);
    check_all("post_reset_lone_b");

    // 3/4 displayed with correct AC drive
    good_frame(3, 4);
    check_all("d34_f1");
    good_frame(3, 4);
    check_all("d34_f2");
    good_frame(3, 4);
    check_all("d34_f3");

    // Counting sequence with wrap (9,0)->(0,1)
    for (int k = 0; k < 11; k++) begin
      for (int f = 0; f < 2; f++) begin
        good_frame(k % 10, (k + 1) % 10);
        check_all($sformatf("count_%0d_%0d", k, f));
      end
    end

    // seg1 held DC showing 8
    frame(7'h7F, tbl[1], 7'h00, tbl[1], 1'b0);
    check_all("dc_held");
    good_frame(5, 1);
    check_all("dc_rec1");

    // "E" pattern then return to 5
    frame(7'h79, tbl[2], 7'h79, tbl[2], 1'b0);
    check_all("pat_e");
    good_frame(5, 2);
    check_all("pat_rec1");
    good_frame(5, 2);
    check_all("pat_rec2");

    // lcdcom stopped: just under, then past the timeout
    wait_cyc(3900);
    check("pre_timeout.com_lost", 32'(com_lost), 32'd0);
    wait_cyc(300);
    m_lost = 1; m_valid = 0; m_agree = 0;
    check_all("timeout");
    good_frame(5, 2);
    check_all("tmo_rec1");
    good_frame(5, 2);
    check_all("tmo_rec2");

    // Short com glitch during phase-A settling must not be captured as phase B
    frame(tbl[6], tbl[7], tbl[6], tbl[7], 1'b1);
    check_all("glitch_f1");
    frame(tbl[6], tbl[7], tbl[6], tbl[7], 1'b1);
    check_all("glitch_f2");

    // Reset between phase A (shows 7) and phase B (shows 1)
    lcdcom = 1'b0; lcdseg1 = tbl[7]; lcdseg2 = tbl[7];
    wait_cyc(HALF);
    rst = 1'b1;
    wait_cyc(3);
    model_reset();
    check_all("rst_mid");
    rst = 1'b0;
    wait_cyc(5);
    lcdcom = 1'b1; lcdseg1 = ~tbl[1]; lcdseg2 = ~tbl[1];
    wait_cyc(HALF);
    check_all("rst_lone_b");
    good_frame(2, 6);
    check_all("rst_rec1");
    good_frame(2, 6);
    check_all("rst_rec2");

    // Randomized frames
    cur1 = 2; cur2 = 6;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 5) begin
        good_frame(cur1, cur2);
      end else if (kind <= 7) begin
        cur1 = int'($urandom_range(0, 9));
        cur2 = int'($urandom_range(0, 9));
        good_frame(cur1, cur2);
      end else if (kind == 8) begin
        bx = tbl[cur1] ^ 7'(1 << $urandom_range(0, 6));
        frame(tbl[cur1], tbl[cur2], bx, tbl[cur2], 1'b0);
      end else begin
        r = 7'($urandom_range(0, 127));
        frame(tbl[cur1], r, tbl[cur1], r, 1'b0);
      end
      check_all($sformatf("rand_%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
